// File: rtl/sap1_pkg.sv
// Shared definitions for the SAP-1 controller and the datapath modules:
// opcode encodings, control-word bit positions and T-state indices.
package sap1_pkg;

    localparam int OPCODE_W = 4;
    localparam int T_STATES = 6;
    localparam int CON_W    = 12;

    // Opcode encodings (IR upper nibble); every other value executes as NOP.
    localparam logic [OPCODE_W-1:0] OP_LDA = 4'h0;
    localparam logic [OPCODE_W-1:0] OP_ADD = 4'h1;
    localparam logic [OPCODE_W-1:0] OP_SUB = 4'h2;
    localparam logic [OPCODE_W-1:0] OP_OUT = 4'hE;
    localparam logic [OPCODE_W-1:0] OP_HLT = 4'hF;

    // Control-word bit positions, all active-high.
    localparam int CON_CP = 11;  // PC increment
    localparam int CON_EP = 10;  // PC to bus
    localparam int CON_LM = 9;   // load MAR
    localparam int CON_CE = 8;   // RAM to bus
    localparam int CON_LI = 7;   // load IR
    localparam int CON_EI = 6;   // IR operand to bus
    localparam int CON_LA = 5;   // load accumulator
    localparam int CON_EA = 4;   // accumulator to bus
    localparam int CON_SU = 3;   // ALU subtract
    localparam int CON_EU = 2;   // ALU to bus
    localparam int CON_LB = 1;   // load B register
    localparam int CON_LO = 0;   // load output register

    // Bit positions of each T-state in the one-hot ring.
    localparam int TS_T1 = 0;
    localparam int TS_T2 = 1;
    localparam int TS_T3 = 2;
    localparam int TS_T4 = 3;
    localparam int TS_T5 = 4;
    localparam int TS_T6 = 5;

    typedef logic [CON_W-1:0] con_t;

    // Instruction class after opcode decode.
    typedef enum logic [2:0] {
        INS_LDA,
        INS_ADD,
        INS_SUB,
        INS_OUT,
        INS_HLT,
        INS_NOP
    } instr_e;

    // Map a raw opcode onto its instruction class; unknown codes are NOP.
    function automatic instr_e decode_op(input logic [OPCODE_W-1:0] op);
        instr_e ins;
        case (op)
            OP_LDA:  ins = INS_LDA;
            OP_ADD:  ins = INS_ADD;
            OP_SUB:  ins = INS_SUB;
            OP_OUT:  ins = INS_OUT;
            OP_HLT:  ins = INS_HLT;
            default: ins = INS_NOP;
        endcase
        return ins;
    endfunction

endpackage

// File: rtl/sap1_controller_ring_counter.sv
// One-hot ring counter: a single 1 circulating from bit 0 upward, wrapping
// from the top bit back to bit 0. Reset parks the ring on bit 0.
module ring_counter #(
    parameter int LEN = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           enable,
    output logic [LEN-1:0] state
);

    // Rotate the single hot bit one position per enabled cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LEN'(1);
        end else if (enable) begin
            state <= {state[LEN-2:0], state[LEN-1]};
        end
    end

endmodule

// File: rtl/sap1_controller.sv
// SAP-1 controller-sequencer: six-state ring counter for the fetch (T1-T3)
// and execute (T4-T6) cycles, a halt flag, and the opcode/T-state decode
// that produces the 12-bit control word for the datapath.
//
// state | meaning
// ------+-------------------------------------------------
// T1    | fetch: PC onto bus, load MAR
// T2    | fetch: PC increment (single-cycle pulse)
// T3    | fetch: RAM onto bus, load IR
// T4    | execute: operand address / OUT transfer / HLT
// T5    | execute: RAM operand into A or B
// T6    | execute: ALU result into A
// HALT  | ring frozen on T4, control word forced to zero
module sap1_controller
    import sap1_pkg::*;
#(
    parameter int OPCODE_W = sap1_pkg::OPCODE_W,
    parameter int T_STATES = sap1_pkg::T_STATES
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    output logic [CON_W-1:0]    con,
    output logic [T_STATES-1:0] t_state,
    output logic                halted
);

    logic [T_STATES-1:0] t_ring;
    logic                ring_enable;
    logic                halt_now;
    instr_e              ins;

    assign ins = decode_op(opcode);

    // HLT is recognised in T4. The ring must not step on that same edge,
    // otherwise it would freeze on T5 instead of T4, so the enable also
    // drops for the halting cycle and not just once the flag is set.
    assign halt_now    = t_ring[TS_T4] & (ins == INS_HLT) & ~halted;
    assign ring_enable = ~(halted | halt_now);

    ring_counter #(
        .LEN (T_STATES)
    ) u_ring (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (ring_enable),
        .state  (t_ring)
    );

    assign t_state = t_ring;

    // Halt flag: set at the end of T4 of a HLT, held until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted <= 1'b0;
        end else if (halt_now) begin
            halted <= 1'b1;
        end
    end

    // Control-word decode. Gating with rst_n keeps strobes off for the whole
    // reset window, including the instant reset lands mid-instruction.
    always_comb begin
        con = '0;
        if (rst_n && !halted) begin
            if (t_ring[TS_T1]) begin
                con[CON_EP] = 1'b1;
                con[CON_LM] = 1'b1;
            end
            if (t_ring[TS_T2]) begin
                con[CON_CP] = 1'b1;
            end
            if (t_ring[TS_T3]) begin
                con[CON_CE] = 1'b1;
                con[CON_LI] = 1'b1;
            end
            if (t_ring[TS_T4]) begin
                case (ins)
                    INS_LDA, INS_ADD, INS_SUB: begin
                        con[CON_EI] = 1'b1;
                        con[CON_LM] = 1'b1;
                    end
                    INS_OUT: begin
                        con[CON_EA] = 1'b1;
                        con[CON_LO] = 1'b1;
                    end
                    default: ;
                endcase
            end
            if (t_ring[TS_T5]) begin
                case (ins)
                    INS_LDA: begin
                        con[CON_CE] = 1'b1;
                        con[CON_LA] = 1'b1;
                    end
                    INS_ADD, INS_SUB: begin
                        con[CON_CE] = 1'b1;
                        con[CON_LB] = 1'b1;
                    end
                    default: ;
                endcase
            end
            if (t_ring[TS_T6]) begin
                case (ins)
                    INS_ADD: begin
                        con[CON_EU] = 1'b1;
                        con[CON_LA] = 1'b1;
                    end
                    INS_SUB: begin
                        con[CON_SU] = 1'b1;
                        con[CON_EU] = 1'b1;
                        con[CON_LA] = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sap1_controller.sv
// Self-checking bench for sap1_controller. The stimulus process drives one
// cycle at a time, pushes the expected outputs for that cycle from a small
// reference model, and a monitor on the falling edge pops and compares.
module tb_sap1_controller;

    logic        clk;
    logic        rst_n;
    logic [3:0]  opcode;
    logic [11:0] con;
    logic [5:0]  t_state;
    logic        halted;

    sap1_controller dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .opcode  (opcode),
        .con     (con),
        .t_state (t_state),
        .halted  (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  ts;
        logic [11:0] con;
        logic        halted;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cp_seen  = 0;
    int m_t      = 0;
    logic m_halted = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Expected control word for a T-state index and opcode, written directly
    // as the hex words of the SAP-1 microprogram.
    function automatic logic [11:0] exp_con(input int t, input logic [3:0] op);
        logic [11:0] w;
        w = 12'h000;
        case (t)
            0: w = 12'h600;
            1: w = 12'h800;
            2: w = 12'h180;
            3: begin
                if (op == 4'h0 || op == 4'h1 || op == 4'h2) w = 12'h240;
                else if (op == 4'hE)                       w = 12'h011;
            end
            4: begin
                if (op == 4'h0)                     w = 12'h120;
                else if (op == 4'h1 || op == 4'h2)  w = 12'h102;
            end
            5: begin
                if (op == 4'h1)      w = 12'h024;
                else if (op == 4'h2) w = 12'h02C;
            end
            default: w = 12'h000;
        endcase
        return w;
    endfunction

    task automatic run_cycle(input logic r, input logic [3:0] op);
        exp_t e;
        rst_n  = r;
        opcode = op;
        if (!r) begin
            m_t      = 0;
            m_halted = 1'b0;
        end
        e.ts     = 6'(1 << m_t);
        e.con    = (!r || m_halted) ? 12'h000 : exp_con(m_t, op);
        e.halted = m_halted;
        sb.push_back(e);
        @(posedge clk);
        if (r && !m_halted) begin
            if (m_t == 3 && op == 4'hF) m_halted = 1'b1;
            else                        m_t = (m_t + 1) % 6;
        end
        #1;
    endtask

    task automatic run_instr(input logic [3:0] op, input logic [3:0] fetch_op);
        for (int i = 0; i < 3; i++) run_cycle(1'b1, fetch_op);
        for (int i = 0; i < 3; i++) run_cycle(1'b1, op);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("t_state", 32'(t_state), 32'(e.ts));
            check("con",     32'(con),     32'(e.con));
            check("halted",  32'(halted),  32'(e.halted));
            if (con[11]) cp_seen++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] ops [8];
        ops = '{4'h0, 4'h1, 4'h2, 4'hE, 4'h3, 4'h7, 4'h9, 4'hC};
        rst_n  = 1'b0;
        opcode = 4'h0;
        @(posedge clk);
        #1;

        // Reset held across three edges, then release into T1.
        repeat (3) run_cycle(1'b0, 4'h0);
        cp_seen = 0;

        // LDA then ADD; CP must pulse once per instruction.
        run_instr(4'h0, 4'h0);
        run_instr(4'h1, 4'($urandom_range(0, 15)));
        check("cp_per_12_cycles", 32'(cp_seen), 32'd2);

        run_instr(4'h2, 4'($urandom_range(0, 15)));
        run_instr(4'hE, 4'($urandom_range(0, 15)));
        run_instr(4'h7, 4'($urandom_range(0, 15)));

        for (int k = 0; k < 8; k++) begin
            run_instr(ops[$urandom_range(0, 7)], 4'($urandom_range(0, 15)));
        end

        // Reset dropped during T5 of ADD, then normal fetch resumes.
        for (int i = 0; i < 3; i++) run_cycle(1'b1, 4'h1);
        run_cycle(1'b1, 4'h1);
        run_cycle(1'b0, 4'h1);
        run_cycle(1'b0, 4'h1);
        run_instr(4'h0, 4'h0);

        // HLT in T4 discarded by a reset arriving before the edge.
        for (int i = 0; i < 3; i++) run_cycle(1'b1, 4'h0);
        run_cycle(1'b0, 4'hF);
        run_instr(4'hE, 4'h0);

        // Real halt: ring frozen on T4, control word zero, opcode ignored.
        for (int i = 0; i < 3; i++) run_cycle(1'b1, 4'hF);
        run_cycle(1'b1, 4'hF);
        repeat (20) run_cycle(1'b1, 4'h1);

        // Only reset leaves the halt.
        run_cycle(1'b0, 4'h0);
        run_instr(4'h2, 4'h0);

        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
